gray_monitor: RTL and testbench
===============================

GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: width of the Gray code input and the binary output (WIDTH >= 2).
REQ-002 The block SHALL have the port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have the port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port Valid, input, 1 bit: Gray is sampled on this edge.
REQ-005 The block SHALL have the port Clear, input, 1 bit: synchronous soft clear of tracking state and flags.
REQ-006 The block SHALL have the port Gray, input, WIDTH bits: reflected-binary Gray code sample.
REQ-007 The block SHALL have the port Bin, output, WIDTH bits: registered binary value of the last accepted sample.
REQ-008 The block SHALL have the port BinValid, output, 1 bit: Bin holds an accepted sample.
REQ-009 The block SHALL have the port Up, output, 1 bit: one-cycle pulse for a +1 step.
REQ-010 The block SHALL have the port Down, output, 1 bit: one-cycle pulse for a -1 step.
REQ-011 The block SHALL have the port Overflow, output, 1 bit: sticky; set on a forward wrap from max to 0.
REQ-012 The block SHALL have the port Underflow, output, 1 bit: sticky; set on a backward wrap from 0 to max.
REQ-013 The block SHALL have the port Error, output, 1 bit: sticky; set on an illegal transition.
REQ-014 The block SHALL have the port StepCount, output, 8 bits: saturating count of accepted +/-1 steps.

Function
REQ-015 Decode SHALL be b[W-1]=g[W-1] and b[i]=b[i+1]^g[i] for i from W-2 down to 0; it is combinational internally, and all outputs are registered.
REQ-016 The FSM SHALL have three states: IDLE (no reference sample), TRACK, ERROR.
REQ-017 In IDLE with Valid=1, the block SHALL load Bin=decode(Gray) and set BinValid=1, with no Up/Down pulse, no count change, and a transition to TRACK.
REQ-018 In TRACK with Valid=1, the block SHALL compute d = decode(Gray) - Bin modulo 2^WIDTH.
REQ-019 In TRACK, d=0 SHALL produce no pulse, no count change and no flag change.
REQ-020 In TRACK, d=1 SHALL load Bin, pulse Up and increment StepCount; if the old Bin was 2^WIDTH-1 and the new value is 0, Overflow SHALL be set.
REQ-021 In TRACK, d=2^WIDTH-1 SHALL load Bin, pulse Down and increment StepCount; if the old Bin was 0 and the new value is 2^WIDTH-1, Underflow SHALL be set.
REQ-022 In TRACK, any other d SHALL set Error, leave Bin holding the last good value, produce no pulse, and move the FSM to ERROR.
REQ-023 In ERROR, Valid SHALL be ignored and all outputs held until Clear or Reset.
REQ-024 Up/Down SHALL be high exactly one cycle after the sampling edge and never both high; Valid=0 SHALL force both low.
REQ-025 StepCount SHALL saturate at 255 and not wrap; Up/Down pulses continue after saturation.
REQ-026 Clear=1 SHALL move the FSM to IDLE and zero BinValid, Up, Down, Overflow, Underflow, Error and StepCount, while Bin holds its value.
REQ-027 Clear SHALL take priority over Valid in the same cycle, and that cycle's sample SHALL be discarded.
REQ-028 Sticky flags SHALL clear only on Clear or Reset.

Reset
REQ-029 Reset=1 at a rising edge SHALL force IDLE, Bin=0, BinValid=0, Up=Down=0, Overflow=Underflow=Error=0 and StepCount=0.
REQ-030 Reset SHALL take priority over Clear and Valid, including mid-sequence and in ERROR.
REQ-031 Reset SHALL be the only mechanism that zeroes Bin.

Verification (WIDTH=3)
REQ-032 Forward count: after Reset, Valid with Gray 000,001,011,010,110 SHALL give Bin 0,1,2,3,4, four Up pulses and StepCount=4.
REQ-033 Forward wrap: from Bin=7 (Gray 100), Gray 000 SHALL give Bin=0, an Up pulse and Overflow=1 (sticky).
REQ-034 Backward wrap: from Bin=0, Gray 100 SHALL give Bin=7, a Down pulse, Underflow=1 and Overflow unchanged.
REQ-035 Illegal jump: from Bin=1 (Gray 001), Gray 101 (6) SHALL set Error=1 with Bin=1; later Valid/Gray SHALL be ignored, and Clear SHALL zero the flags with the next Valid reloading from IDLE.
REQ-036 Hold and priority: a repeated 011 SHALL give no pulse and no count change; Clear=1 with Valid=1 SHALL discard the sample (BinValid=0); Reset mid-sequence SHALL give Bin=0 and StepCount=0.
REQ-037 Saturation: 300 alternating +1/-1 steps SHALL leave StepCount=255 with pulses continuing.

Source files
------------

// File: rtl/gray_monitor.sv
// Gray-code position monitor: decodes each accepted sample, tracks +/-1 steps,
// counts them with saturation and latches wrap and illegal-jump flags.
module gray_monitor #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Bin,
  output logic             BinValid,
  output logic             Up,
  output logic             Down,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Error,
  output logic [7:0]       StepCount
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    ERROR
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_d;
  logic [WIDTH-1:0] decoded, diff;
  logic [WIDTH-1:0] bin_d;
  logic             bin_valid_d, up_d, down_d;
  logic             overflow_d, underflow_d, error_d;
  logic [7:0]       step_count_d;

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] acc;
    acc = g;
    for (int k = 1; k < WIDTH; k++) acc ^= g >> k;
    return acc;
  endfunction

  assign decoded = gray_to_bin(Gray);
  assign diff    = decoded - Bin;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state;
    bin_d        = Bin;
    bin_valid_d  = BinValid;
    up_d         = 1'b0;
    down_d       = 1'b0;
    overflow_d   = Overflow;
    underflow_d  = Underflow;
    error_d      = Error;
    step_count_d = StepCount;

    if (Clear) begin
      // Bin is deliberately kept; only Reset zeroes it.
      state_d      = IDLE;
      bin_valid_d  = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      error_d      = 1'b0;
      step_count_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (Valid) begin
            bin_d       = decoded;
            bin_valid_d = 1'b1;
            state_d     = TRACK;
          end
        end
        TRACK: begin
          if (Valid && diff != '0) begin
            if (diff == ONE || diff == ALL_ONES) begin
              bin_d = decoded;
              if (StepCount != 8'hFF) step_count_d = StepCount + 8'd1;
              if (diff == ONE) begin
                up_d = 1'b1;
                if (Bin == ALL_ONES) overflow_d = 1'b1;
              end else begin
                down_d = 1'b1;
                if (Bin == '0) underflow_d = 1'b1;
              end
            end else begin
              error_d = 1'b1;
              state_d = ERROR;
            end
          end
        end
        ERROR:   ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state     <= IDLE;
      Bin       <= '0;
      BinValid  <= 1'b0;
      Up        <= 1'b0;
      Down      <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Error     <= 1'b0;
      StepCount <= '0;
    end else begin
      state     <= state_d;
      Bin       <= bin_d;
      BinValid  <= bin_valid_d;
      Up        <= up_d;
      Down      <= down_d;
      Overflow  <= overflow_d;
      Underflow <= underflow_d;
      Error     <= error_d;
      StepCount <= step_count_d;
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Directed self-checking bench for gray_monitor at WIDTH=3 with hand-computed
// expected values.
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset, Valid, Clear;
  logic [2:0] Gray;
  logic [2:0] Bin;
  logic       BinValid, Up, Down, Overflow, Underflow, Error;
  logic [7:0] StepCount;

  int checks = 0;
  int errors = 0;

  gray_monitor #(.WIDTH(3)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Valid     (Valid),
    .Clear     (Clear),
    .Gray      (Gray),
    .Bin       (Bin),
    .BinValid  (BinValid),
    .Up        (Up),
    .Down      (Down),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Error     (Error),
    .StepCount (StepCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Apply one set of inputs for exactly one rising edge, then settle past it.
  task automatic step(input logic v, input logic c, input logic r, input logic [2:0] g);
    @(negedge Clk);
    Valid = v;
    Clear = c;
    Reset = r;
    Gray  = g;
    @(posedge Clk);
    #1;
  endtask

  // Check Bin, pulses, count and the three sticky flags in one call.
  task automatic expect_all(input string tag, input logic [2:0] b, input logic bv,
                            input logic u, input logic d, input logic [7:0] cnt,
                            input logic ov, input logic un, input logic er);
    check({tag, ".bin"},   32'(Bin),       32'(b));
    check({tag, ".bv"},    32'(BinValid),  32'(bv));
    check({tag, ".up"},    32'(Up),        32'(u));
    check({tag, ".down"},  32'(Down),      32'(d));
    check({tag, ".count"}, 32'(StepCount), 32'(cnt));
    check({tag, ".ovf"},   32'(Overflow),  32'(ov));
    check({tag, ".unf"},   32'(Underflow), 32'(un));
    check({tag, ".err"},   32'(Error),     32'(er));
  endtask

  logic [2:0] fwd_gray [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

  initial begin
    Reset = 1'b1; Valid = 1'b0; Clear = 1'b0; Gray = 3'b000;

    step(1'b1, 1'b0, 1'b1, 3'b101);
    step(1'b0, 1'b0, 1'b1, 3'b000);
    expect_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Forward count 0..4; the first sample only loads the reference.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, fwd_gray[i]);
      expect_all($sformatf("fwd%0d", i), 3'(i), 1'b1, (i != 0), 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
    end

    step(1'b1, 1'b0, 1'b0, 3'b010);   // 4 -> 3
    expect_all("down3", 3'd3, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b011);   // 3 -> 2
    expect_all("down2", 3'd2, 1'b1, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b011);   // repeated sample
    expect_all("hold", 3'd2, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b110);   // Valid low ignores a would-be error
    expect_all("novalid", 3'd2, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 3'b010);   // 3
    step(1'b1, 1'b0, 1'b0, 3'b110);   // 4
    step(1'b1, 1'b0, 1'b0, 3'b111);   // 5
    step(1'b1, 1'b0, 1'b0, 3'b101);   // 6
    step(1'b1, 1'b0, 1'b0, 3'b100);   // 7
    expect_all("at7", 3'd7, 1'b1, 1'b1, 1'b0, 8'd11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b000);   // 7 -> 0 forward wrap
    expect_all("ovf", 3'd0, 1'b1, 1'b1, 1'b0, 8'd12, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b000);
    expect_all("ovf_sticky", 3'd0, 1'b1, 1'b0, 1'b0, 8'd12, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b100);   // 0 -> 7 backward wrap
    expect_all("unf", 3'd7, 1'b1, 1'b0, 1'b1, 8'd13, 1'b1, 1'b1, 1'b0);

    step(1'b1, 1'b0, 1'b0, 3'b000);   // 0
    step(1'b1, 1'b0, 1'b0, 3'b001);   // 1
    expect_all("at1", 3'd1, 1'b1, 1'b1, 1'b0, 8'd15, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b101);   // 1 -> 6 illegal
    expect_all("illegal", 3'd1, 1'b1, 1'b0, 1'b0, 8'd15, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'b011);   // ignored while in error
    expect_all("err_hold", 3'd1, 1'b1, 1'b0, 1'b0, 8'd15, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'b000);
    expect_all("clear", 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b111);   // reload 5 from idle, no pulse
    expect_all("reload", 3'd5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0, 3'b000);   // Clear beats Valid; sample dropped
    expect_all("clr_prio", 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b100);   // fresh reference 7, not a step
    expect_all("reload7", 3'd7, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b000);   // 0, wrap
    step(1'b1, 1'b0, 1'b0, 3'b001);   // 1
    expect_all("pre_rst", 3'd1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'b011);   // Reset beats Clear and Valid
    expect_all("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b110);   // 0 -> 4 illegal
    check("err_set", 32'(Error), 32'd1);
    step(1'b0, 1'b0, 1'b1, 3'b000);
    expect_all("err_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Saturation: 300 alternating +1/-1 steps from reference 0.
    step(1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 3'b001 : 3'b000);
      if (i == 253) check("sat_254", 32'(StepCount), 32'd254);
      if (i == 254) check("sat_255", 32'(StepCount), 32'd255);
      if (i == 298) check("sat_up",  32'(Up),        32'd1);
    end
    expect_all("sat_end", 3'd0, 1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
